mdio_arbiter: RTL and testbench

Shares the single MDIO engine (`mdio` instance, 2.5 MHz domain) between two requesters: the PHY configuration sequencer (port `cfg`) and the host register-access path driven by protocol commands (port `host`). It arbitrates round-robin and sequences each granted access onto the engine's request/ready handshake. For host Clause-22 indirect (MMD) accesses, it issues the four-frame 0x0D/0x0E sequence atomically. Per-frame timeout prevents a hung PHY from locking out either requester.

---
 rtl/mdio_arb_pkg.sv | 80 ++++++++
 rtl/mdio_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mdio_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_arb_pkg.sv
// Shared types and helpers for the two-requester MDIO engine arbiter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mdio_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_ACK
    } arb_state_t;

    // Function field of the MMD access control register (bits 15:14)
    localparam logic [1:0] MMD_FN_ADDR = 2'b00;
    localparam logic [1:0] MMD_FN_DATA = 2'b01;

    // Index of the final frame of an indirect MMD sequence
    localparam logic [1:0] MMD_LAST_STEP = 2'd3;

    // Read data returned on abort, and for write transactions
    localparam logic [15:0] RDATA_DEFAULT = 16'hFFFF;
    localparam logic [15:0] RDATA_WRITE   = 16'h0000;

    // One engine frame: direction, register address, write data
    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } frame_t;

    function automatic logic [15:0] mmd_ctrl(input logic [1:0] fn, input logic [4:0] devad);
        return {fn, 9'b0, devad};
    endfunction

    // Frame to put on the engine for a given step of a transaction.
    // Direct accesses are a single frame; MMD accesses walk the 0x0D/0x0E sequence.
    function automatic frame_t frame_for_step(
        input logic        mmd,
        input logic        wr,
        input logic [4:0]  devad,
        input logic [15:0] addr,
        input logic [15:0] wdata,
        input logic [1:0]  step,
        input logic [4:0]  ctrl_addr,
        input logic [4:0]  data_addr
    );
        frame_t f;
        f.wr   = wr;
        f.addr = addr[4:0];
        f.data = wdata;
        if (mmd) begin
            case (step)
                2'd0: begin
                    f.wr   = 1'b1;
                    f.addr = ctrl_addr;
                    f.data = mmd_ctrl(MMD_FN_ADDR, devad);
                end
                2'd1: begin
                    f.wr   = 1'b1;
                    f.addr = data_addr;
                    f.data = addr;
                end
                2'd2: begin
                    f.wr   = 1'b1;
                    f.addr = ctrl_addr;
                    f.data = mmd_ctrl(MMD_FN_DATA, devad);
                end
                default: begin
                    f.wr   = wr;
                    f.addr = data_addr;
                    f.data = wdata;
                end
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO engine between the cfg sequencer and host access path.
// Latency: grant -> ISSUE 1 cycle; ack 1 cycle after the final frame's eng_ready returns.
// Backpressure: requesters hold req until ack; grants only when the engine reports ready; per-frame timeout.
module mdio_arbiter
    import mdio_arb_pkg::*;
#(
    parameter int         TIMEOUT_CYC   = 4096,
    parameter logic [4:0] MMD_CTRL_ADDR = 5'h0d,
    parameter logic [4:0] MMD_DATA_ADDR = 5'h0e
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        cfg_req,
    input  logic        cfg_wr,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        cfg_ack,
    output logic [15:0] cfg_rdata,
    output logic        cfg_err,

    input  logic        host_req,
    input  logic        host_wr,
    input  logic        host_mmd,
    input  logic [4:0]  host_devad,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        host_err,

    input  logic        eng_ready,
    input  logic [15:0] eng_rd_data,
    output logic        eng_rd_request,
    output logic        eng_wr_request,
    output logic [4:0]  eng_addr,
    output logic [15:0] eng_wr_data,

    output logic        busy,
    output logic        grant_host
);

    localparam logic [12:0] TIMEOUT_VAL = 13'(TIMEOUT_CYC);

    arb_state_t  state;
    logic [1:0]  step;
    logic [12:0] timer;
    logic        last_host;      // arbitration history, resets to host so cfg wins the first tie

    // Request fields captured at grant
    logic        lat_host;
    logic        lat_mmd;
    logic        lat_wr;
    logic [4:0]  lat_devad;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;

    logic        req_any;
    logic        pick_host;
    logic        new_mmd;
    logic        new_wr;
    logic [4:0]  new_devad;
    logic [15:0] new_addr;
    logic [15:0] new_wdata;
    frame_t      grant_frame;
    frame_t      next_frame;
    logic        last_step;
    logic        timed_out;
    logic        done_ok;
    logic        finish_now;
    logic [15:0] finish_rdata;

    // Winner selection, first/next frame contents and completion conditions
    always_comb begin
        req_any   = cfg_req | host_req;
        pick_host = host_req & (~cfg_req | ~last_host);

        if (pick_host) begin
            new_mmd   = host_mmd;
            new_wr    = host_wr;
            new_devad = host_devad;
            new_addr  = host_addr;
            new_wdata = host_wdata;
        end else begin
            new_mmd   = 1'b0;
            new_wr    = cfg_wr;
            new_devad = 5'd0;
            new_addr  = {11'b0, cfg_addr};
            new_wdata = cfg_wdata;
        end

        grant_frame = frame_for_step(new_mmd, new_wr, new_devad, new_addr, new_wdata,
                                     2'd0, MMD_CTRL_ADDR, MMD_DATA_ADDR);
        next_frame  = frame_for_step(lat_mmd, lat_wr, lat_devad, lat_addr, lat_wdata,
                                     step + 2'd1, MMD_CTRL_ADDR, MMD_DATA_ADDR);

        last_step    = ~lat_mmd | (step == MMD_LAST_STEP);
        timed_out    = ((state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE)) && (timer == TIMEOUT_VAL);
        done_ok      = (state == ST_WAIT_DONE) & eng_ready & ~timed_out & last_step;
        finish_now   = timed_out | done_ok;
        // The final frame's direction is always the requester's wr bit
        finish_rdata = timed_out ? RDATA_DEFAULT : (lat_wr ? RDATA_WRITE : eng_rd_data);
    end

    // Transaction sequencer with registered engine handshake and completion outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            step           <= 2'd0;
            timer          <= 13'd0;
            last_host      <= 1'b1;
            lat_host       <= 1'b0;
            lat_mmd        <= 1'b0;
            lat_wr         <= 1'b0;
            lat_devad      <= 5'd0;
            lat_addr       <= 16'd0;
            lat_wdata      <= 16'd0;
            cfg_ack        <= 1'b0;
            cfg_rdata      <= 16'd0;
            cfg_err        <= 1'b0;
            host_ack       <= 1'b0;
            host_rdata     <= 16'd0;
            host_err       <= 1'b0;
            eng_rd_request <= 1'b0;
            eng_wr_request <= 1'b0;
            eng_addr       <= 5'd0;
            eng_wr_data    <= 16'd0;
            busy           <= 1'b0;
            grant_host     <= 1'b0;
        end else begin
            eng_rd_request <= 1'b0;
            eng_wr_request <= 1'b0;
            cfg_ack        <= 1'b0;
            cfg_err        <= 1'b0;
            host_ack       <= 1'b0;
            host_err       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // eng_ready gating also lets a frame left over from a reset finish first
                    if (eng_ready && req_any) begin
                        lat_host       <= pick_host;
                        lat_mmd        <= new_mmd;
                        lat_wr         <= new_wr;
                        lat_devad      <= new_devad;
                        lat_addr       <= new_addr;
                        lat_wdata      <= new_wdata;
                        last_host      <= pick_host;
                        grant_host     <= pick_host;
                        busy           <= 1'b1;
                        step           <= 2'd0;
                        eng_addr       <= grant_frame.addr;
                        eng_wr_data    <= grant_frame.data;
                        eng_wr_request <= grant_frame.wr;
                        eng_rd_request <= ~grant_frame.wr;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= 13'd0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    timer <= timer + 13'd1;
                    if (!eng_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    timer <= timer + 13'd1;
                    if (eng_ready && !last_step) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    step           <= step + 2'd1;
                    eng_addr       <= next_frame.addr;
                    eng_wr_data    <= next_frame.data;
                    eng_wr_request <= next_frame.wr;
                    eng_rd_request <= ~next_frame.wr;
                    state          <= ST_ISSUE;
                end
                ST_ACK: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Normal completion or abort: skip any remaining MMD steps and report
            if (finish_now) begin
                state <= ST_ACK;
                if (lat_host) begin
                    host_ack   <= 1'b1;
                    host_rdata <= finish_rdata;
                    host_err   <= timed_out;
                end else begin
                    cfg_ack    <= 1'b1;
                    cfg_rdata  <= finish_rdata;
                    cfg_err    <= timed_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
module tb_mdio_arbiter;

    localparam int T = 4096;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cfg_req, cfg_wr;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_ack, cfg_err;
    logic [15:0] cfg_rdata;
    logic        host_req, host_wr, host_mmd;
    logic [4:0]  host_devad;
    logic [15:0] host_addr, host_wdata;
    logic        host_ack, host_err;
    logic [15:0] host_rdata;
    logic        eng_ready;
    logic [15:0] eng_rd_data;
    logic        eng_rd_request, eng_wr_request;
    logic [4:0]  eng_addr;
    logic [15:0] eng_wr_data;
    logic        busy, grant_host;

    always #5 clock = ~clock;

    mdio_arbiter #(.TIMEOUT_CYC(T), .MMD_CTRL_ADDR(5'h0d), .MMD_DATA_ADDR(5'h0e)) dut (
        .clock(clock), .reset_n(reset_n),
        .cfg_req(cfg_req), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
        .host_req(host_req), .host_wr(host_wr), .host_mmd(host_mmd), .host_devad(host_devad),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
        .eng_ready(eng_ready), .eng_rd_data(eng_rd_data),
        .eng_rd_request(eng_rd_request), .eng_wr_request(eng_wr_request),
        .eng_addr(eng_addr), .eng_wr_data(eng_wr_data),
        .busy(busy), .grant_host(grant_host)
    );

    typedef struct packed { logic wr; logic [4:0] addr; logic [15:0] data; } frm_t;
    typedef struct packed { logic host; logic [15:0] rdata; logic err; } ack_t;

    frm_t exp_frm[$];
    ack_t exp_ack[$];
    frm_t frm_log[$];
    logic ack_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic model_last_host = 1'b1;

    int          eng_lat = 3;
    bit          eng_hang = 1'b0;
    bit          eng_busy = 1'b0;
    int          eng_cnt = 0;
    logic [15:0] eng_rd_val = 16'h0000;
    int          ready_rise_cyc = -100;
    int          issue_cyc = -100;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction expands into the frames and the single ack it must produce
    task automatic expect_txn(input logic host, input logic mmd, input logic wr,
                              input logic [4:0] devad, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rd, input bit tmo);
        ack_t a;
        if (!mmd || tmo) begin
            exp_frm.push_back({wr, addr[4:0], wdata});
        end else begin
            exp_frm.push_back({1'b1, 5'h0d, 16'h0000 | {11'b0, devad}});
            exp_frm.push_back({1'b1, 5'h0e, addr});
            exp_frm.push_back({1'b1, 5'h0d, 16'h4000 | {11'b0, devad}});
            exp_frm.push_back({wr,   5'h0e, wdata});
        end
        a.host  = host;
        a.rdata = tmo ? 16'hFFFF : (wr ? 16'h0000 : rd);
        a.err   = tmo;
        exp_ack.push_back(a);
        model_last_host = host;
    endtask

    // Engine model: takes a request, drops ready, returns it eng_lat cycles later (unless hung)
    initial begin
        eng_ready   = 1'b1;
        eng_rd_data = 16'h0000;
        forever begin
            @(posedge clock);
            #2;
            if (eng_busy) begin
                if (!eng_hang) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_ready      = 1'b1;
                        eng_rd_data    = eng_rd_val;
                        eng_busy       = 1'b0;
                        ready_rise_cyc = cyc;
                    end
                end
            end else if (eng_rd_request || eng_wr_request) begin
                frm_log.push_back({eng_wr_request, eng_addr, eng_wr_data});
                eng_busy  = 1'b1;
                eng_cnt   = eng_lat;
                eng_ready = 1'b0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model queues
    initial begin
        logic prev_ready;
        logic prev_ack;
        frm_t f;
        ack_t a;
        prev_ready = 1'b1;
        prev_ack   = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (eng_rd_request || eng_wr_request) begin
                    issue_cyc = cyc;
                    chk("req_exclusive", 32'(eng_rd_request & eng_wr_request), 32'd0);
                    chk("req_after_ready", 32'(prev_ready), 32'd1);
                    chk("busy_at_req", 32'(busy), 32'd1);
                    if (exp_frm.size() == 0) begin
                        chk("unexpected_frame", 32'({eng_wr_request, eng_addr}), 32'hFFFF_FFFF);
                    end else begin
                        f = exp_frm.pop_front();
                        chk("frame_wr", 32'(eng_wr_request), 32'(f.wr));
                        chk("frame_addr", 32'(eng_addr), 32'(f.addr));
                        if (f.wr) chk("frame_data", 32'(eng_wr_data), 32'(f.data));
                    end
                end
                if (cfg_ack || host_ack) begin
                    chk("ack_exclusive", 32'(cfg_ack & host_ack), 32'd0);
                    chk("ack_one_cycle", 32'(prev_ack), 32'd0);
                    chk("busy_at_ack", 32'(busy), 32'd1);
                    if (exp_ack.size() == 0) begin
                        chk("unexpected_ack", 32'({cfg_ack, host_ack}), 32'd0);
                    end else begin
                        a = exp_ack.pop_front();
                        chk("ack_port", 32'(host_ack), 32'(a.host));
                        chk("ack_grant", 32'(grant_host), 32'(a.host));
                        chk("ack_rdata", 32'(host_ack ? host_rdata : cfg_rdata), 32'(a.rdata));
                        chk("ack_err", 32'(host_ack ? host_err : cfg_err), 32'(a.err));
                        if (a.err) chk("timeout_latency", 32'(cyc - issue_cyc), 32'(T + 2));
                        else       chk("ack_latency", 32'(cyc - ready_rise_cyc), 32'd1);
                    end
                    ack_log.push_back(host_ack);
                end
                if (eng_busy && busy && frm_log.size() > 0) begin
                    f = frm_log[frm_log.size() - 1];
                    chk("frame_stable", 32'({eng_addr, eng_wr_data}), 32'({f.addr, f.data}));
                end
            end
            prev_ready = eng_ready;
            prev_ack   = cfg_ack | host_ack;
        end
    end

    task automatic cfg_txn(input logic wr, input logic [4:0] addr, input logic [15:0] wd);
        bit got = 1'b0;
        bit scr = 1'b0;
        @(negedge clock);
        cfg_wr = wr; cfg_addr = addr; cfg_wdata = wd; cfg_req = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            if (cfg_ack) begin got = 1'b1; break; end
            // fields must have been captured at grant; disturb them afterwards
            if (!scr && busy && !grant_host) begin
                scr = 1'b1; cfg_wr = ~wr; cfg_addr = ~addr; cfg_wdata = ~wd;
            end
        end
        if (!got) chk("cfg_ack_wait", 32'd0, 32'd1);
        cfg_req = 1'b0;
    endtask

    task automatic host_txn(input logic wr, input logic mmd, input logic [4:0] devad,
                            input logic [15:0] addr, input logic [15:0] wd);
        bit got = 1'b0;
        bit scr = 1'b0;
        @(negedge clock);
        host_wr = wr; host_mmd = mmd; host_devad = devad; host_addr = addr; host_wdata = wd;
        host_req = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            if (host_ack) begin got = 1'b1; break; end
            if (!scr && busy && grant_host) begin
                scr = 1'b1; host_wr = ~wr; host_mmd = ~mmd; host_devad = ~devad;
                host_addr = ~addr; host_wdata = ~wd;
            end
        end
        if (!got) chk("host_ack_wait", 32'd0, 32'd1);
        host_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acks_errs"}, 32'({cfg_ack, host_ack, cfg_err, host_err}), 32'd0);
        chk({tag, "_eng_req"}, 32'({eng_rd_request, eng_wr_request}), 32'd0);
        chk({tag, "_busy_grant"}, 32'({busy, grant_host}), 32'd0);
        chk({tag, "_rdata"}, {cfg_rdata, host_rdata}, 32'd0);
        chk({tag, "_eng_fields"}, 32'({eng_addr, eng_wr_data}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        bit got;
        frm_t f;
        reset_n = 1'b0;
        cfg_req = 1'b0; cfg_wr = 1'b0; cfg_addr = 5'd0; cfg_wdata = 16'd0;
        host_req = 1'b0; host_wr = 1'b0; host_mmd = 1'b0; host_devad = 5'd0;
        host_addr = 16'd0; host_wdata = 16'd0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // cfg write addr 0 data 0x1300: one write frame, err clear
        expect_txn(1'b0, 1'b0, 1'b1, 5'd0, 16'h0000, 16'h1300, 16'h0000, 1'b0);
        cfg_txn(1'b1, 5'd0, 16'h1300);
        chk("cfgw_frames", 32'(frm_log.size()), 32'd1);
        chk("cfgw_frame0", 32'(frm_log[0]), 32'({1'b1, 5'd0, 16'h1300}));
        chk("cfgw_rdata", 32'(cfg_rdata), 32'h0000);

        // cfg direct read
        eng_rd_val = 16'hBEEF;
        expect_txn(1'b0, 1'b0, 1'b0, 5'd0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
        cfg_txn(1'b0, 5'd5, 16'h0000);
        chk("cfgr_rdata", 32'(cfg_rdata), 32'h0000BEEF);

        // host direct write: only addr[4:0] reaches the engine
        expect_txn(1'b1, 1'b0, 1'b1, 5'd0, 16'hFFE3, 16'hA5A5, 16'h0000, 1'b0);
        host_txn(1'b1, 1'b0, 5'd0, 16'hFFE3, 16'hA5A5);
        f = frm_log[frm_log.size() - 1];
        chk("hostw_addr", 32'(f.addr), 32'h3);

        // host MMD read devad 2 addr 8
        eng_rd_val = 16'h7777;
        base = frm_log.size();
        expect_txn(1'b1, 1'b1, 1'b0, 5'd2, 16'h0008, 16'h0000, 16'h7777, 1'b0);
        host_txn(1'b0, 1'b1, 5'd2, 16'h0008, 16'h0000);
        chk("mmd_frames", 32'(frm_log.size() - base), 32'd4);
        chk("mmd_f0", 32'(frm_log[base]),     32'({1'b1, 5'h0d, 16'h0002}));
        chk("mmd_f1", 32'(frm_log[base + 1]), 32'({1'b1, 5'h0e, 16'h0008}));
        chk("mmd_f2", 32'(frm_log[base + 2]), 32'({1'b1, 5'h0d, 16'h4002}));
        f = frm_log[base + 3];
        chk("mmd_f3", 32'({f.wr, f.addr}), 32'({1'b0, 5'h0e}));
        chk("mmd_rdata", 32'(host_rdata), 32'h7777);

        // host MMD write
        expect_txn(1'b1, 1'b1, 1'b1, 5'h1f, 16'h1234, 16'h5678, 16'h0000, 1'b0);
        host_txn(1'b1, 1'b1, 5'h1f, 16'h1234, 16'h5678);
        chk("mmdw_rdata", 32'(host_rdata), 32'h0000);

        // simultaneous requests, twice: round-robin winner first, host MMD kept whole
        for (int r = 0; r < 2; r++) begin
            eng_rd_val = 16'h1100 + 16'(r);
            if (model_last_host) begin
                expect_txn(1'b0, 1'b0, 1'b1, 5'd0, 16'h0004, 16'h00C0 + 16'(r), 16'h0000, 1'b0);
                expect_txn(1'b1, 1'b1, 1'b0, 5'd1, 16'h0010 + 16'(r), 16'h0000, eng_rd_val, 1'b0);
            end else begin
                expect_txn(1'b1, 1'b1, 1'b0, 5'd1, 16'h0010 + 16'(r), 16'h0000, eng_rd_val, 1'b0);
                expect_txn(1'b0, 1'b0, 1'b1, 5'd0, 16'h0004, 16'h00C0 + 16'(r), 16'h0000, 1'b0);
            end
            fork
                cfg_txn(1'b1, 5'd4, 16'h00C0 + 16'(r));
                host_txn(1'b0, 1'b1, 5'd1, 16'h0010 + 16'(r), 16'h0000);
            join
        end
        n = ack_log.size();
        chk("tie_order", 32'({ack_log[n - 4], ack_log[n - 3], ack_log[n - 2], ack_log[n - 1]}), 32'b0101);

        // hung engine: abort with err and all-ones data, then normal service
        eng_hang = 1'b1;
        expect_txn(1'b0, 1'b0, 1'b0, 5'd0, 16'h0007, 16'h0000, 16'h0000, 1'b1);
        cfg_txn(1'b0, 5'd7, 16'h0000);
        chk("tmo_rdata", 32'(cfg_rdata), 32'hFFFF);
        eng_hang = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (eng_ready) begin got = 1'b1; break; end
        end
        chk("tmo_engine_recover", 32'(got), 32'd1);
        expect_txn(1'b0, 1'b0, 1'b1, 5'd0, 16'h0009, 16'h0042, 16'h0000, 1'b0);
        cfg_txn(1'b1, 5'd9, 16'h0042);
        chk("post_tmo_rdata", 32'(cfg_rdata), 32'h0000);

        // reset during MMD step 2; the in-flight frame must finish before the next ISSUE
        eng_lat = 20;
        base = frm_log.size();
        expect_txn(1'b1, 1'b1, 1'b0, 5'd3, 16'h0021, 16'h0000, 16'h0000, 1'b0);
        @(negedge clock);
        host_mmd = 1'b1; host_wr = 1'b0; host_devad = 5'd3; host_addr = 16'h0021;
        host_wdata = 16'h0000; host_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (frm_log.size() == base + 3) begin got = 1'b1; break; end
        end
        chk("rst_reach_step2", 32'(got), 32'd1);
        reset_n = 1'b0;
        host_req = 1'b0;
        exp_frm.delete();
        exp_ack.delete();
        model_last_host = 1'b1;
        @(negedge clock);
        check_reset_outputs("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        eng_lat = 3;
        eng_rd_val = 16'h0BAD;
        expect_txn(1'b0, 1'b0, 1'b0, 5'd0, 16'h0001, 16'h0000, 16'h0BAD, 1'b0);
        cfg_txn(1'b0, 5'd1, 16'h0000);
        chk("rst_frames", 32'(frm_log.size() - base), 32'd4);
        f = frm_log[frm_log.size() - 1];
        chk("rst_cfg_frame", 32'({f.wr, f.addr}), 32'({1'b0, 5'd1}));
        chk("rst_cfg_rdata", 32'(cfg_rdata), 32'h0BAD);
        chk("leftover_frames", 32'(exp_frm.size()), 32'd0);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
